pll_ctrl_master: RTL and testbench
==================================

# pll_ctrl_master

Avalon-MM master that issues single read, write and poll transactions to the PLL control slave's 3-bit, 16-bit register space. It sits between a simple command port and the slave. Typical users are a boot sequencer or a debug/LCD status path. Poll mode re-reads a register until a masked compare matches or a retry limit expires, for example waiting on a status bit.

## Interface
- ADDR_W, 3, Avalon address width
- DATA_W, 16, data width
- READ_LATENCY, 0, fixed slave read latency in cycles after read is accepted; legal 0..3
- POLL_MAX, 1024, maximum poll reads before timeout; legal 1..65535
- POLL_GAP, 4, idle cycles between poll reads; legal 0..255
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved
- cmd_addr  in  ADDR_W  register address
- cmd_wdata  in  DATA_W  write data (write) / compare value (poll)
- cmd_mask  in  DATA_W  poll compare mask; ignored otherwise
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  DATA_W  read/poll data; 0 for write
- rsp_error  out  1  poll timeout or reserved op; valid with rsp_valid
- avm_address  out  ADDR_W
- avm_chipselect  out  1
- avm_read  out  1
- avm_write  out  1
- avm_writedata  out  DATA_W
- avm_readdata  in  DATA_W
- avm_waitrequest  in  1  slave stall; tie 0 for slaves without it

## Operation
- States: IDLE, ISSUE, RDWAIT, GAP, RESP.
- IDLE to ISSUE on accept; command fields latched. op 11 goes IDLE to RESP with rsp_error=1, rsp_data=0 and no bus cycle.
- ISSUE: avm_chipselect=1, with avm_read or avm_write=1; address/data stable. Held while avm_waitrequest=1.
- ISSUE exit on the cycle with waitrequest=0:
  - write goes to RESP.
  - read/poll with READ_LATENCY=0 samples avm_readdata that cycle.
  - read/poll with READ_LATENCY>0 goes to RDWAIT, counts READ_LATENCY cycles, then samples.
- After sample:
  - read goes to RESP with rsp_data=sample.
  - poll goes to RESP when (sample & mask)==(wdata & mask), rsp_error=0.
  - poll otherwise increments the attempt count. When the count reaches POLL_MAX it goes to RESP with rsp_data=last sample, rsp_error=1. Otherwise it goes to GAP for POLL_GAP cycles, then back to ISSUE (GAP skipped if POLL_GAP=0).
- RESP: rsp_valid=1 for one cycle, then IDLE.
- Attempt counter is 16 bits, cleared on accept, never wraps; the POLL_MAX check precedes increment overflow.
- avm_read and avm_write are never high together. Bus controls are 0 outside ISSUE.

## Timing
- All outputs are registered.
- Reset values: cmd_ready=0 during reset and 1 the cycle after; all other outputs 0, state IDLE.
- Reset mid-transfer drops the bus cycle immediately with no response.
- Write with no stall: accept at T, avm_write at T+1, rsp_valid at T+2.
- Read with READ_LATENCY=0 and no stall: read at T+1, sample at T+1, rsp at T+2.
- READ_LATENCY=L: rsp at T+2+L.
- Each waitrequest cycle adds one cycle.
- Poll retry period is 1+L+POLL_GAP cycles per attempt plus stalls.
- Reserved op: rsp_valid at T+1.
- cmd_valid while busy is ignored; cmd_ready=0 from T+1 through the RESP cycle.

## Structure
- Package pll_ctrl_pkg holds:
  - op encodings OP_WRITE/OP_READ/OP_POLL/OP_RSVD
  - state enum
  - register addresses REG_STATUS=0, REG_CONTROL=1
  - default widths
- Single module; no sub-module. Latency, gap and attempt counters are inline.

## Test plan
- Write addr 1, data 0x0003, waitrequest=0: avm_write=1 only at T+1 with writedata 0x0003; rsp_valid at T+2, rsp_data=0, rsp_error=0.
- Read addr 0, READ_LATENCY=2, slave returns 0x00A5 two cycles after accept: rsp_data=0x00A5 at T+4.
- Write with waitrequest high 3 cycles: address/data held constant for 4 ISSUE cycles; rsp at T+5.
- Poll addr 0, mask 0x0001, compare 0x0001, bit set on the 3rd read, POLL_GAP=4: exactly 3 reads; rsp_error=0, rsp_data has bit0=1.
- Poll with POLL_MAX=5 and bit never set: exactly 5 reads; rsp_error=1, rsp_data=last read value.
- op=11 gives rsp_error=1 at T+1 and no avm activity. Reset asserted during a poll GAP clears all outputs; the next command runs normally.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared encodings and defaults for the PLL control master
// Contents: command op encodings, master FSM states, PLL control register map,
// default bus widths.
package pll_ctrl_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 16;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_GAP    = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/pll_ctrl_master.sv
// rtl/pll_ctrl_master.sv - Avalon-MM master for single write/read/poll to the PLL control slave
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; ready only while idle
//   cmd_op/addr/wdata/mask     op (write/read/poll/reserved), address, write or compare data, poll mask
//   rsp_valid/rsp_data/rsp_error  one-cycle response pulse with read data and error flag
//   avm_*                      Avalon-MM master port (address, chipselect, read, write, data, waitrequest)
module pll_ctrl_master
    import pll_ctrl_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 0,
    parameter int POLL_MAX     = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    // Counters load N-1 so that RDWAIT lasts READ_LATENCY cycles and GAP lasts POLL_GAP cycles.
    localparam logic [1:0]  LAT_LOAD   = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [7:0]  GAP_LOAD   = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
    localparam logic [16:0] POLL_LIMIT = 17'(POLL_MAX);

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mask_q;
    logic [1:0]        lat_cnt;
    logic [7:0]        gap_cnt;
    logic [15:0]       attempt_cnt;

    logic              sample_now;
    logic              poll_hit;
    logic [16:0]       attempt_next;

    // Read data is captured either in the accepting ISSUE cycle (zero latency)
    // or in the last RDWAIT cycle.
    always_comb begin
        sample_now = 1'b0;
        if (state == ST_ISSUE && !avm_waitrequest && op_q != OP_WRITE && READ_LATENCY == 0)
            sample_now = 1'b1;
        if (state == ST_RDWAIT && lat_cnt == 2'd0)
            sample_now = 1'b1;
    end

    assign poll_hit     = ((avm_readdata ^ wdata_q) & mask_q) == '0;
    // 17-bit sum so the limit compare is taken before the 16-bit counter could overflow.
    assign attempt_next = {1'b0, attempt_cnt} + 17'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            op_q           <= OP_WRITE;
            addr_q         <= '0;
            wdata_q        <= '0;
            mask_q         <= '0;
            lat_cnt        <= '0;
            gap_cnt        <= '0;
            attempt_cnt    <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            rsp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        op_q        <= op_t'(cmd_op);
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        mask_q      <= cmd_mask;
                        attempt_cnt <= '0;
                        if (op_t'(cmd_op) == OP_RSVD) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_error <= 1'b1;
                        end else begin
                            state          <= ST_ISSUE;
                            avm_chipselect <= 1'b1;
                            avm_address    <= cmd_addr;
                            avm_read       <= (op_t'(cmd_op) != OP_WRITE);
                            avm_write      <= (op_t'(cmd_op) == OP_WRITE);
                            avm_writedata  <= (op_t'(cmd_op) == OP_WRITE) ? cmd_wdata : '0;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (!avm_waitrequest) begin
                        avm_chipselect <= 1'b0;
                        avm_read       <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_address    <= '0;
                        avm_writedata  <= '0;
                        if (op_q == OP_WRITE) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_error <= 1'b0;
                        end else if (READ_LATENCY != 0) begin
                            state   <= ST_RDWAIT;
                            lat_cnt <= LAT_LOAD;
                        end
                    end
                end

                ST_RDWAIT: begin
                    if (lat_cnt != 2'd0)
                        lat_cnt <= lat_cnt - 2'd1;
                end

                ST_GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else begin
                        state          <= ST_ISSUE;
                        avm_chipselect <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= addr_q;
                    end
                end

                ST_RESP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: state <= ST_IDLE;
            endcase

            // Sample handling overrides the per-state defaults above.
            if (sample_now) begin
                if (op_q == OP_READ || poll_hit) begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= avm_readdata;
                    rsp_error <= 1'b0;
                end else if (attempt_next >= POLL_LIMIT) begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= avm_readdata;
                    rsp_error <= 1'b1;
                end else begin
                    attempt_cnt <= attempt_next[15:0];
                    if (POLL_GAP == 0) begin
                        state          <= ST_ISSUE;
                        avm_chipselect <= 1'b1;
                        avm_read       <= 1'b1;
                        avm_address    <= addr_q;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pll_ctrl_master.sv
// tb/tb_pll_ctrl_master.sv - scoreboard bench for pll_ctrl_master with a behavioural slave
module tb_pll_ctrl_master;

    localparam int AW   = 3;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int PMAX = 5;
    localparam int PGAP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_mask;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    always #5 clk = ~clk;

    pll_ctrl_master #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT), .POLL_MAX(PMAX), .POLL_GAP(PGAP)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    typedef struct {
        int op;
        int addr;
        int wdata;
        int tacc;
        int trsp;
        int data;
        int err;
        int nrd;
        int nwr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // behavioural slave state
    int          stall_n = 0;
    int          wcnt = 0;
    logic [15:0] rd_vals[$];
    int          rd_idx = 0;
    logic [15:0] sched[8];
    bit          sched_v[8];
    int          nrd_seen = 0;
    int          nwr_seen = 0;
    int          first_bus = -1;
    exp_t        mon_e;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave, bus monitor and response monitor all act mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            avm_readdata    = '0;
            avm_waitrequest = 1'b0;
            wcnt      = 0;
            nrd_seen  = 0;
            nwr_seen  = 0;
            first_bus = -1;
            for (int i = 0; i < 8; i++) sched_v[i] = 1'b0;
        end else begin
            avm_readdata = sched_v[cyc % 8] ? sched[cyc % 8] : DW'($urandom);
            sched_v[cyc % 8] = 1'b0;
            avm_waitrequest = avm_chipselect && (wcnt < stall_n);

            if (avm_read && avm_write) chk("rd_wr_exclusive", 1, 0);

            if (exp_q.size() > 0 && cyc > exp_q[0].tacc) chk("busy_cmd_ready", cmd_ready, 0);

            if (avm_chipselect) begin
                if (exp_q.size() > 0) begin
                    chk("bus_addr", avm_address, exp_q[0].addr);
                    chk("bus_read", avm_read, exp_q[0].op != 0);
                    chk("bus_write", avm_write, exp_q[0].op == 0);
                    if (exp_q[0].op == 0) chk("bus_wdata", avm_writedata, exp_q[0].wdata);
                    if (first_bus < 0) begin
                        first_bus = cyc;
                        chk("bus_start", cyc, exp_q[0].tacc + 1);
                    end
                end else begin
                    chk("bus_no_cmd", avm_chipselect, 0);
                end
                if (avm_waitrequest) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (avm_read) begin
                        nrd_seen++;
                        if (rd_vals.size() > 0)
                            sched[(cyc + LAT) % 8] = rd_vals[(rd_idx < rd_vals.size()) ? rd_idx : rd_vals.size() - 1];
                        else
                            sched[(cyc + LAT) % 8] = DW'($urandom);
                        sched_v[(cyc + LAT) % 8] = 1'b1;
                        rd_idx++;
                    end
                    if (avm_write) nwr_seen++;
                end
            end else begin
                if (avm_read || avm_write) chk("bus_ctrl_idle", {avm_read, avm_write}, 0);
            end

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, mon_e.data);
                    chk("rsp_error", rsp_error, mon_e.err);
                    chk("rsp_cycle", cyc, mon_e.trsp);
                    chk("rsp_nreads", nrd_seen, mon_e.nrd);
                    chk("rsp_nwrites", nwr_seen, mon_e.nwr);
                end
                nrd_seen  = 0;
                nwr_seen  = 0;
                first_bus = -1;
            end
        end
    end

    function automatic int val_at(input logic [15:0] vals[$], input int i);
        if (vals.size() == 0) return 0;
        return (i < vals.size()) ? vals[i] : vals[vals.size() - 1];
    endfunction

    // Issue one command; the expected response is derived from the op rules and timing.
    task automatic send(input int op, input int addr, input int wd, input int mask,
                        input int stall, input logic [15:0] vals[$]);
        exp_t e;
        int   n = 0;
        int   k;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", cmd_ready, 1);
            return;
        end
        stall_n   = stall;
        rd_vals   = vals;
        rd_idx    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        cmd_addr  = addr[AW-1:0];
        cmd_wdata = wd[DW-1:0];
        cmd_mask  = mask[DW-1:0];

        e.op = op; e.addr = addr; e.wdata = wd & 16'hFFFF; e.tacc = cyc;
        e.data = 0; e.err = 0; e.nrd = 0; e.nwr = 0;
        case (op)
            0: begin e.nwr = 1; e.trsp = cyc + 2 + stall; end
            1: begin e.nrd = 1; e.data = val_at(vals, 0); e.trsp = cyc + 2 + LAT + stall; end
            2: begin
                k = PMAX;
                e.err = 1;
                e.data = val_at(vals, PMAX - 1);
                for (int i = 0; i < PMAX; i++) begin
                    if (((val_at(vals, i) ^ wd) & mask & 16'hFFFF) == 0) begin
                        k = i + 1;
                        e.err = 0;
                        e.data = val_at(vals, i);
                        break;
                    end
                end
                e.nrd  = k;
                e.trsp = cyc + k * (1 + LAT + stall) + (k - 1) * PGAP + 1;
            end
            default: begin e.err = 1; e.trsp = cyc + 1; end
        endcase
        exp_q.push_back(e);

        // One cycle of command noise while busy; it must be ignored.
        @(negedge clk);
        cmd_op    = 2'($urandom);
        cmd_wdata = DW'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_chipselect", avm_chipselect, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_address", avm_address, 0);
        chk("rst_writedata", avm_writedata, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [15:0] v[$];
        int op, wd, mask, j;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        avm_readdata = '0; avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);

        // directed cases
        v = {16'h0000};
        send(0, 1, 16'h0003, 0, 0, v);
        wait_idle();
        v = {16'h00A5};
        send(1, 0, 0, 0, 0, v);
        wait_idle();
        send(0, 1, 16'h1234, 0, 3, v);
        wait_idle();
        v = {16'h0000, 16'h0000, 16'h0001};
        send(2, 0, 16'h0001, 16'h0001, 0, v);
        wait_idle();
        v = {16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h000A, 16'h000E};
        send(2, 0, 16'h0001, 16'h0001, 0, v);
        wait_idle();
        send(3, 2, 16'hFFFF, 16'hFFFF, 0, v);
        wait_idle();

        // reset while the poll sits in its inter-read gap
        v = {16'h0000};
        send(2, 0, 16'h0001, 16'h0001, 0, v);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", cmd_ready, 1);
        v = {16'h0055};
        send(1, 1, 0, 0, 1, v);
        wait_idle();

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 9);
            op = (op < 3) ? 0 : (op < 6) ? 1 : (op < 9) ? 2 : 3;
            wd   = $urandom_range(0, 16'hFFFF);
            mask = $urandom_range(1, 16'hFFFF);
            v.delete();
            for (int i = 0; i < $urandom_range(1, PMAX + 1); i++) v.push_back(16'($urandom));
            if (op == 2 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, v.size() - 1);
                v[j] = 16'((($urandom) & ~mask) | (wd & mask));
            end
            send(op, $urandom_range(0, 7), wd, mask, $urandom_range(0, 2), v);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
